// File: rtl/dma64_mem_responder.sv
// Memory-side responder for the 64-bit DMA ctrl/chnl interface, backed by a local word-addressed memory.
// Latency: first read beat one cycle after request accept; one beat per cycle sustained in both directions.
// Backpressure: read beats are held stable until chnl_ready; write beats are taken whenever chnl_ready is high.
// Optional feature: define DMA64_RESP_STALL_EN to add LFSR-driven throughput stalls on both channels.
module dma64_mem_responder #(
  parameter int         MEM_WORDS = 1024,
  parameter logic [2:0] SIZE_64   = 3'd3,
  parameter int         AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dma_read_ctrl_valid,
  input  logic [31:0]   dma_read_ctrl_data_index,
  input  logic [31:0]   dma_read_ctrl_data_length,
  input  logic [2:0]    dma_read_ctrl_data_size,
  output logic          dma_read_ctrl_ready,
  output logic          dma_read_chnl_valid,
  output logic [63:0]   dma_read_chnl_data,
  input  logic          dma_read_chnl_ready,
  input  logic          dma_write_ctrl_valid,
  input  logic [31:0]   dma_write_ctrl_data_index,
  input  logic [31:0]   dma_write_ctrl_data_length,
  input  logic [2:0]    dma_write_ctrl_data_size,
  output logic          dma_write_ctrl_ready,
  input  logic          dma_write_chnl_valid,
  input  logic [63:0]   dma_write_chnl_data,
  output logic          dma_write_chnl_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [63:0]   host_wdata,
  output logic [63:0]   host_rdata,
  output logic          busy,
  output logic          err
);

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;
  typedef enum logic {WR_IDLE, WR_STREAM} wr_state_t;

  logic [63:0] mem [MEM_WORDS];

  rd_state_t   rd_state, rd_state_nxt;
  logic        rd_ctrl_rdy, rd_ctrl_rdy_nxt;
  logic        rd_vld, rd_vld_nxt;
  logic [63:0] rd_dat, rd_dat_nxt;
  logic [AW-1:0] rd_addr, rd_addr_nxt, rd_addr_inc;
  logic [31:0] rd_rem, rd_rem_nxt;

  wr_state_t   wr_state, wr_state_nxt;
  logic        wr_ctrl_rdy, wr_ctrl_rdy_nxt;
  logic        wr_rdy, wr_rdy_nxt;
  logic [AW-1:0] wr_addr, wr_addr_nxt;
  logic [31:0] wr_rem, wr_rem_nxt;

  logic rd_acc, wr_acc, rd_hs, wr_hs, err_set, stall;

`ifdef DMA64_RESP_STALL_EN
  logic [15:0] lfsr;
  // Fibonacci LFSR, taps 16/14/13/11; bit 0 decides whether this cycle stalls.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign dma_read_ctrl_ready  = rd_ctrl_rdy;
  assign dma_read_chnl_valid  = rd_vld;
  assign dma_read_chnl_data   = rd_dat;
  assign dma_write_ctrl_ready = wr_ctrl_rdy;
  assign dma_write_chnl_ready = wr_rdy & ~stall;
  assign host_rdata           = mem[host_addr];

  assign rd_acc      = dma_read_ctrl_valid & rd_ctrl_rdy;
  assign wr_acc      = dma_write_ctrl_valid & wr_ctrl_rdy;
  assign rd_hs       = rd_vld & dma_read_chnl_ready;
  assign wr_hs       = dma_write_chnl_valid & dma_write_chnl_ready & ~rst;
  assign rd_addr_inc = rd_addr + 1'b1;
  assign busy        = (rd_state != RD_IDLE) | (wr_state != WR_IDLE);

  // Out-of-range index, non-64-bit size and host writes while busy all latch the sticky error.
  assign err_set = (rd_acc & ((|dma_read_ctrl_data_index[31:AW]) | (dma_read_ctrl_data_size != SIZE_64)))
                 | (wr_acc & ((|dma_write_ctrl_data_index[31:AW]) | (dma_write_ctrl_data_size != SIZE_64)))
                 | (host_we & busy);

  // Read engine next state: load a beat on accept or on handshake, hold it while the initiator stalls.
  always_comb begin
    rd_state_nxt    = rd_state;
    rd_ctrl_rdy_nxt = rd_ctrl_rdy;
    rd_vld_nxt      = rd_vld;
    rd_dat_nxt      = rd_dat;
    rd_addr_nxt     = rd_addr;
    rd_rem_nxt      = rd_rem;
    case (rd_state)
      RD_IDLE: begin
        rd_ctrl_rdy_nxt = 1'b1;
        if (rd_acc) begin
          rd_ctrl_rdy_nxt = 1'b0;
          rd_addr_nxt     = dma_read_ctrl_data_index[AW-1:0];
          rd_rem_nxt      = dma_read_ctrl_data_length;
          if (dma_read_ctrl_data_length != 32'd0) begin
            rd_state_nxt = RD_STREAM;
            rd_vld_nxt   = ~stall;
            rd_dat_nxt   = mem[dma_read_ctrl_data_index[AW-1:0]];
          end
        end
      end
      RD_STREAM: begin
        if (rd_hs) begin
          rd_rem_nxt = rd_rem - 32'd1;
          if (rd_rem == 32'd1) begin
            rd_vld_nxt      = 1'b0;
            rd_state_nxt    = RD_IDLE;
            rd_ctrl_rdy_nxt = 1'b1;
          end else begin
            rd_addr_nxt = rd_addr_inc;
            rd_vld_nxt  = ~stall;
            rd_dat_nxt  = mem[rd_addr_inc];
          end
        end else if (!rd_vld && !stall) begin
          // A beat deferred by a stall is presented once the stall clears.
          rd_vld_nxt = 1'b1;
          rd_dat_nxt = mem[rd_addr];
        end
      end
    endcase
  end

  // Read engine state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state    <= RD_IDLE;
      rd_ctrl_rdy <= 1'b0;
      rd_vld      <= 1'b0;
      rd_dat      <= 64'd0;
      rd_addr     <= '0;
      rd_rem      <= 32'd0;
    end else begin
      rd_state    <= rd_state_nxt;
      rd_ctrl_rdy <= rd_ctrl_rdy_nxt;
      rd_vld      <= rd_vld_nxt;
      rd_dat      <= rd_dat_nxt;
      rd_addr     <= rd_addr_nxt;
      rd_rem      <= rd_rem_nxt;
    end
  end

  // Write engine next state: open the channel after accept, close it after the last beat.
  always_comb begin
    wr_state_nxt    = wr_state;
    wr_ctrl_rdy_nxt = wr_ctrl_rdy;
    wr_rdy_nxt      = wr_rdy;
    wr_addr_nxt     = wr_addr;
    wr_rem_nxt      = wr_rem;
    case (wr_state)
      WR_IDLE: begin
        wr_ctrl_rdy_nxt = 1'b1;
        if (wr_acc) begin
          wr_ctrl_rdy_nxt = 1'b0;
          wr_addr_nxt     = dma_write_ctrl_data_index[AW-1:0];
          wr_rem_nxt      = dma_write_ctrl_data_length;
          if (dma_write_ctrl_data_length != 32'd0) begin
            wr_state_nxt = WR_STREAM;
            wr_rdy_nxt   = 1'b1;
          end
        end
      end
      WR_STREAM: begin
        if (wr_hs) begin
          wr_rem_nxt  = wr_rem - 32'd1;
          wr_addr_nxt = wr_addr + 1'b1;
          if (wr_rem == 32'd1) begin
            wr_rdy_nxt      = 1'b0;
            wr_state_nxt    = WR_IDLE;
            wr_ctrl_rdy_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  // Write engine state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= WR_IDLE;
      wr_ctrl_rdy <= 1'b0;
      wr_rdy      <= 1'b0;
      wr_addr     <= '0;
      wr_rem      <= 32'd0;
    end else begin
      wr_state    <= wr_state_nxt;
      wr_ctrl_rdy <= wr_ctrl_rdy_nxt;
      wr_rdy      <= wr_rdy_nxt;
      wr_addr     <= wr_addr_nxt;
      wr_rem      <= wr_rem_nxt;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Memory write port; contents survive reset. Host writes only land while both engines are idle.
  always_ff @(posedge clk) begin
    if (wr_hs)                mem[wr_addr]   <= dma_write_chnl_data;
    else if (host_we && !busy) mem[host_addr] <= host_wdata;
  end

endmodule

// File: tb/tb_dma64_mem_responder.sv
module tb_dma64_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_cv = 0, rd_rdy = 0, wr_cv = 0, wr_dv = 0, host_we = 0;
  logic [31:0] rd_idx = 0, rd_len = 0, wr_idx = 0, wr_len = 0;
  logic [2:0]  rd_sz = 3'd3, wr_sz = 3'd3;
  logic [63:0] wr_dd = 0, host_wdata = 0;
  logic [9:0]  host_addr = 0;
  logic        rd_ctrl_ready, rd_chnl_valid, wr_ctrl_ready, wr_chnl_ready, busy, err;
  logic [63:0] rd_chnl_data, host_rdata;

  int          n_pass = 0, n_total = 0, cyc = 0, beats_seen = 0;
  logic [63:0] exp_q[$];
  int          beat_cyc[$];
  logic [63:0] model[1024];
  logic        hold_pending = 0;
  logic [63:0] hold_data = 0;

  dma64_mem_responder dut (
    .clk(clk), .rst(rst),
    .dma_read_ctrl_valid(rd_cv), .dma_read_ctrl_data_index(rd_idx),
    .dma_read_ctrl_data_length(rd_len), .dma_read_ctrl_data_size(rd_sz),
    .dma_read_ctrl_ready(rd_ctrl_ready), .dma_read_chnl_valid(rd_chnl_valid),
    .dma_read_chnl_data(rd_chnl_data), .dma_read_chnl_ready(rd_rdy),
    .dma_write_ctrl_valid(wr_cv), .dma_write_ctrl_data_index(wr_idx),
    .dma_write_ctrl_data_length(wr_len), .dma_write_ctrl_data_size(wr_sz),
    .dma_write_ctrl_ready(wr_ctrl_ready), .dma_write_chnl_valid(wr_dv),
    .dma_write_chnl_data(wr_dd), .dma_write_chnl_ready(wr_chnl_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every read handshake pops one expected beat; stalled beats must stay put.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pending) begin
        n_total++;
        if (rd_chnl_valid !== 1'b1 || rd_chnl_data !== hold_data)
          $display("FAIL beat_hold: valid=%b data=%h required valid=1 data=%h", rd_chnl_valid, rd_chnl_data, hold_data);
        else n_pass++;
      end
      hold_pending = rd_chnl_valid && !rd_rdy;
      hold_data    = rd_chnl_data;
      if (rd_chnl_valid && rd_rdy) begin
        beats_seen++;
        beat_cyc.push_back(cyc);
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_beat: data=%h with nothing expected", rd_chnl_data);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if (rd_chnl_data !== e) $display("FAIL read_beat: got %h required %h", rd_chnl_data, e);
          else n_pass++;
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic host_write(input int a, input logic [63:0] d, input bit upd);
    @(posedge clk); #1;
    host_we = 1'b1; host_addr = 10'(a); host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
    if (upd) model[a] = d;
  endtask

  task automatic issue_read(input int idx, input int len, input logic [2:0] sz);
    bit ok = 0;
    @(posedge clk); #1;
    rd_cv = 1'b1; rd_idx = idx; rd_len = len; rd_sz = sz;
    for (int k = 0; k < len; k++) exp_q.push_back(model[(idx + k) % 1024]);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rd_ctrl_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_total++; $display("FAIL rd_accept: ctrl_ready=%b required 1 within 50 cycles", rd_ctrl_ready); end
    @(posedge clk); #1;
    rd_cv = 1'b0;
  endtask

  task automatic issue_write(input int idx, input int len, input logic [2:0] sz);
    bit ok = 0;
    @(posedge clk); #1;
    wr_cv = 1'b1; wr_idx = idx; wr_len = len; wr_sz = sz;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (wr_ctrl_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_total++; $display("FAIL wr_accept: ctrl_ready=%b required 1 within 50 cycles", wr_ctrl_ready); end
    @(posedge clk); #1;
    wr_cv = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    n_total++;
    if (!ok) $display("FAIL %s_drain: pending=%0d busy=%b required 0/0", nm, exp_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if ({rd_ctrl_ready, rd_chnl_valid, wr_ctrl_ready, wr_chnl_ready, busy, err} !== 6'b0 || rd_chnl_data !== 64'd0)
      $display("FAIL reset_outputs: flags=%b data=%h required 0", {rd_ctrl_ready, rd_chnl_valid, wr_ctrl_ready, wr_chnl_ready, busy, err}, rd_chnl_data);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({rd_ctrl_ready, wr_ctrl_ready} !== 2'b00) $display("FAIL ready_after_release: got %b required 00", {rd_ctrl_ready, wr_ctrl_ready});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({rd_ctrl_ready, wr_ctrl_ready} !== 2'b11) $display("FAIL ready_next_cycle: got %b required 11", {rd_ctrl_ready, wr_ctrl_ready});
    else n_pass++;
  endtask

  task automatic test_preload_read();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] nib;
      nib = 4'(i + 1);
      host_write(i, {16{nib}}, 1);
    end
    host_addr = 10'd2; #1;
    n_total++;
    if (host_rdata !== 64'h3333_3333_3333_3333) $display("FAIL host_rdata: got %h required %h", host_rdata, 64'h3333_3333_3333_3333);
    else n_pass++;
    rd_rdy = 1'b1;
    beat_cyc.delete();
    issue_read(0, 4, 3'd3);
    wait_drain("burst4");
    n_total++;
    if (beat_cyc.size() != 4 || beat_cyc[beat_cyc.size()-1] - beat_cyc[0] != 3)
      $display("FAIL burst_consecutive: beats=%0d span=%0d required 4 beats span 3", beat_cyc.size(),
               beat_cyc.size() > 0 ? beat_cyc[beat_cyc.size()-1] - beat_cyc[0] : -1);
    else n_pass++;
  endtask

  task automatic test_ready_toggle();
    int base;
    base = beats_seen;
    rd_rdy = 1'b0;
    issue_read(8, 4, 3'd3);
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1 rd_rdy = ~rd_rdy;
      if (exp_q.size() == 0) break;
    end
    rd_rdy = 1'b1;
    wait_drain("toggle");
    repeat (3) @(posedge clk);
    n_total++;
    if (beats_seen - base != 4) $display("FAIL toggle_count: got %0d beats required 4", beats_seen - base);
    else n_pass++;
  endtask

  task automatic test_write_wrap();
    issue_write(1020, 8, 3'd3);
    for (int k = 0; k < 8; k++) begin
      bit ok = 0;
      wr_dv = 1'b1; wr_dd = 64'(k);
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (wr_chnl_ready) begin ok = 1; break; end
      end
      if (!ok) begin n_total++; $display("FAIL wr_beat_ready: got 0 required 1 within 50 cycles"); end
      @(posedge clk); #1;
      model[(1020 + k) % 1024] = 64'(k);
    end
    wr_dv = 1'b0;
    wait_drain("wrap");
    for (int k = 0; k < 8; k++) begin
      host_addr = 10'((1020 + k) % 1024); #1;
      n_total++;
      if (host_rdata !== model[(1020 + k) % 1024]) $display("FAIL wrap_mem: addr=%0d got %h required %h", host_addr, host_rdata, model[(1020 + k) % 1024]);
      else n_pass++;
    end
    n_total++;
    if (err !== 1'b0) $display("FAIL wrap_err: got %b required 0", err);
    else n_pass++;
  endtask

  task automatic test_concurrent();
    bit ok = 0;
    host_write(4, 64'h4444_0000_0000_0004, 1);
    host_write(5, 64'hBEEF, 1);
    rd_rdy = 1'b1;
    @(posedge clk); #1;
    rd_cv = 1'b1; rd_idx = 4; rd_len = 2; rd_sz = 3'd3;
    wr_cv = 1'b1; wr_idx = 5; wr_len = 1; wr_sz = 3'd3;
    exp_q.push_back(64'h4444_0000_0000_0004);
    exp_q.push_back(64'hBEEF);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rd_ctrl_ready && wr_ctrl_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_total++; $display("FAIL concurrent_accept: readies=%b%b required 11", rd_ctrl_ready, wr_ctrl_ready); end
    @(posedge clk); #1;
    rd_cv = 1'b0; wr_cv = 1'b0; wr_dv = 1'b1; wr_dd = 64'hDEAD;
    @(negedge clk);
    n_total++;
    if (wr_chnl_ready !== 1'b1) $display("FAIL concurrent_wr_ready: got %b required 1", wr_chnl_ready);
    else n_pass++;
    @(posedge clk); #1;
    wr_dv = 1'b0;
    model[5] = 64'hDEAD;
    wait_drain("concurrent");
    host_addr = 10'd5; #1;
    n_total++;
    if (host_rdata !== 64'hDEAD) $display("FAIL concurrent_mem5: got %h required %h", host_rdata, 64'hDEAD);
    else n_pass++;
  endtask

  task automatic test_len0();
    issue_read(3, 0, 3'd3);
    @(negedge clk);
    n_total++;
    if ({rd_ctrl_ready, rd_chnl_valid, busy} !== 3'b000) $display("FAIL len0_after_accept: ready/valid/busy=%b required 000", {rd_ctrl_ready, rd_chnl_valid, busy});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({rd_ctrl_ready, rd_chnl_valid} !== 2'b10) $display("FAIL len0_ready_back: ready/valid=%b required 10", {rd_ctrl_ready, rd_chnl_valid});
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL len0_err: got %b required 0", err);
    else n_pass++;
  endtask

  task automatic test_host_drop();
    host_write(100, 64'h0123_4567_89AB_CDEF, 1);
    rd_rdy = 1'b0;
    issue_read(0, 2, 3'd3);
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL busy_during_read: got %b required 1", busy);
    else n_pass++;
    host_write(100, 64'hBAD0, 0);
    rd_rdy = 1'b1;
    wait_drain("host_drop");
    host_addr = 10'd100; #1;
    n_total++;
    if (host_rdata !== model[100]) $display("FAIL host_drop_mem: got %h required %h", host_rdata, model[100]);
    else n_pass++;
    n_total++;
    if (err !== 1'b1) $display("FAIL host_drop_err: got %b required 1", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok = 0;
    rd_rdy = 1'b1;
    base = beats_seen;
    issue_read(0, 8, 3'd3);
    for (int t = 0; t < 50; t++) begin
      if (beats_seen >= base + 3) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin n_total++; $display("FAIL reset_mid_beats: got %0d required 3", beats_seen - base); end
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({rd_chnl_valid, rd_ctrl_ready, busy} !== 3'b000) $display("FAIL reset_mid_state: valid/ready/busy=%b required 000", {rd_chnl_valid, rd_ctrl_ready, busy});
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (rd_ctrl_ready !== 1'b0) $display("FAIL reset_mid_ready_low: got %b required 0", rd_ctrl_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rd_ctrl_ready !== 1'b1 || err !== 1'b0) $display("FAIL reset_mid_ready_high: ready=%b err=%b required 1/0", rd_ctrl_ready, err);
    else n_pass++;
    issue_read(2, 3, 3'd3);
    wait_drain("after_reset");
  endtask

  task automatic test_size_err();
    issue_read(0, 1, 3'd2);
    wait_drain("size");
    n_total++;
    if (err !== 1'b1) $display("FAIL size_err: got %b required 1", err);
    else n_pass++;
  endtask

  task automatic test_index_oob();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (err !== 1'b0) $display("FAIL oob_err_cleared: got %b required 0", err);
    else n_pass++;
    issue_read(1024 + 7, 1, 3'd3);
    wait_drain("oob");
    n_total++;
    if (err !== 1'b1) $display("FAIL oob_err: got %b required 1", err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_ready_toggle();
    test_write_wrap();
    test_concurrent();
    test_len0();
    test_host_drop();
    test_reset_mid();
    test_size_err();
    test_index_oob();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
